// File: rtl/parity_frame_pkg.sv
// Shared types and helpers for the parity frame transmitter.
// Holds the frame state encoding, line-level constants and a clog2 that never returns 0.
package parity_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/parity_baud_tick.sv
// Per-bit cycle counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// tick_next looks one cycle ahead so downstream outputs can be registered.
module parity_baud_tick
   import parity_frame_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick,
   output logic tick_next
);

   localparam int               CNT_W = clog2_min1(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clr || tick) cnt_d = '0;
   end

   assign tick_next = (cnt_d == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/parity_frame_tx.sv
// Serialises a data word plus its precomputed parity bit as start, data (LSB first),
// parity, stop; every bit held CLKS_PER_BIT cycles, back-to-back frames supported.
module parity_frame_tx
   import parity_frame_pkg::*;
#(
   parameter int DATA_W       = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_parity,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam int               IDX_W    = clog2_min1(DATA_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              par_q, par_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              frame_done_q, frame_done_d;
   logic              tick, tick_next, hs;

   assign in_ready = !rst && ((state_q == IDLE) || ((state_q == STOP) && tick));
   assign hs       = in_valid && in_ready;

   // Counter is held at zero while idle so a new frame always starts on a fresh bit.
   parity_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
      .clk       (clk),
      .rst       (rst),
      .clr       (hs || (state_q == IDLE)),
      .tick      (tick),
      .tick_next (tick_next)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      case (state_q)
         IDLE:   state_d = IDLE;
         START:  if (tick) state_d = DATA;
         DATA: begin
            if (tick) begin
               shreg_d = shreg_q >> 1;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = PARITY;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         PARITY: if (tick) state_d = STOP;
         STOP:   if (tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (hs) begin
         state_d = START;
         shreg_d = in_data;
         par_d   = in_parity;
         idx_d   = '0;
      end
   end

   // Outputs are derived from next-state so the registered line tracks the FSM without lag.
   always_comb begin
      case (state_d)
         START:   tx_d = START_BIT;
         DATA:    tx_d = shreg_d[0];
         PARITY:  tx_d = par_d;
         STOP:    tx_d = STOP_BIT;
         default: tx_d = STOP_BIT;
      endcase
      busy_d       = (state_d != IDLE);
      frame_done_d = (state_d == STOP) && tick_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         shreg_q      <= '0;
         par_q        <= 1'b0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         shreg_q      <= shreg_d;
         par_q        <= par_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: directed frames plus random ones on a 4-cycle and a 1-cycle divider,
// each cycle compared against the frame bit sequence built from the word and parity.
module tb_parity_frame_tx;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   vld, rdy, tx, busy, fd;
   logic [W-1:0] in_data;
   logic         in_parity;
   int           checks   = 0;
   int           failures = 0;

   always #5 clk = ~clk;

   parity_frame_tx #(.DATA_W(W), .CLKS_PER_BIT(4)) dut_a (
      .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(in_data),
      .in_parity(in_parity), .tx(tx[0]), .busy(busy[0]), .frame_done(fd[0])
   );

   parity_frame_tx #(.DATA_W(W), .CLKS_PER_BIT(1)) dut_b (
      .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(in_data),
      .in_parity(in_parity), .tx(tx[1]), .busy(busy[1]), .frame_done(fd[1])
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Frame bit b: 0 start, 1..W data LSB first, W+1 parity, W+2 stop.
   function automatic logic exp_bit(input logic [W-1:0] d, input logic p, input int b);
      if (b == 0) return 1'b0;
      if (b <= W) return d[b-1];
      if (b == W + 1) return p;
      return 1'b1;
   endfunction

   // Called at a negedge while the selected block is idle; offers the word for the next edge.
   task automatic start(input int sel, input logic [W-1:0] d, input logic p);
      chk($sformatf("idle_tx%0d", sel), tx[sel], 1'b1);
      chk($sformatf("idle_busy%0d", sel), busy[sel], 1'b0);
      chk($sformatf("idle_rdy%0d", sel), rdy[sel], 1'b1);
      in_data   = d;
      in_parity = p;
      vld[sel]  = 1'b1;
   endtask

   // Checks one whole frame cycle by cycle; the handshake edge is the next posedge.
   task automatic frame(input int sel, input logic [W-1:0] d, input logic p, input bit chain,
                        input logic [W-1:0] nd, input logic np, input int abort_at);
      int cpb = (sel == 0) ? 4 : 1;
      int len = (W + 3) * cpb;
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         chk($sformatf("tx%0d_d%h_k%0d", sel, d, k), tx[sel], exp_bit(d, p, k / cpb));
         chk($sformatf("busy%0d_k%0d", sel, k), busy[sel], 1'b1);
         chk($sformatf("done%0d_k%0d", sel, k), fd[sel], k == len - 1);
         chk($sformatf("rdy%0d_k%0d", sel, k), rdy[sel], k == len - 1);
         if (k == abort_at) begin
            rst = 1'b1;
            #1;
            chk("rst_tx", tx[sel], 1'b1);
            chk("rst_busy", busy[sel], 1'b0);
            chk("rst_done", fd[sel], 1'b0);
            chk("rst_rdy", rdy[sel], 1'b0);
            @(negedge clk);
            rst      = 1'b0;
            vld[sel] = 1'b0;
            return;
         end
         if (k == len - 1) begin
            vld[sel]  = chain;
            in_data   = nd;
            in_parity = np;
         end else begin
            vld[sel]  = 1'($urandom);
            in_data   = W'($urandom);
            in_parity = 1'($urandom);
         end
      end
   endtask

   initial begin
      logic [W-1:0] d, nd;
      logic         p, np;
      bit           ch;
      int           s;

      rst = 1'b1; vld = '0; in_data = '0; in_parity = 1'b0;
      #2;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("reset_tx%0d", i), tx[i], 1'b1);
         chk($sformatf("reset_busy%0d", i), busy[i], 1'b0);
         chk($sformatf("reset_done%0d", i), fd[i], 1'b0);
         chk($sformatf("reset_rdy%0d", i), rdy[i], 1'b0);
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      @(negedge clk); start(0, 4'b1011, 1'b1);
      frame(0, 4'b1011, 1'b1, 1'b0, 4'h0, 1'b0, -1);

      @(negedge clk); start(0, 4'b0001, 1'b1);
      frame(0, 4'b0001, 1'b1, 1'b1, 4'b1110, 1'b1, -1);
      frame(0, 4'b1110, 1'b1, 1'b0, 4'h0, 1'b0, -1);

      // Cycles 8..11 are the second data bit at four cycles per bit.
      @(negedge clk); start(0, 4'b0110, 1'b1);
      frame(0, 4'b0110, 1'b1, 1'b0, 4'h0, 1'b0, 9);
      @(negedge clk); start(0, 4'b0101, 1'b0);
      frame(0, 4'b0101, 1'b0, 1'b0, 4'h0, 1'b0, -1);

      @(negedge clk); start(1, 4'b1111, 1'b0);
      frame(1, 4'b1111, 1'b0, 1'b0, 4'h0, 1'b0, -1);

      s = int'($urandom_range(1, 0));
      d = W'($urandom); p = 1'($urandom);
      @(negedge clk); start(s, d, p);
      repeat (10) begin
         nd = W'($urandom); np = 1'($urandom); ch = 1'($urandom);
         frame(s, d, p, ch, nd, np, -1);
         if (!ch) begin
            s = int'($urandom_range(1, 0));
            @(negedge clk); start(s, nd, np);
         end
         d = nd; p = np;
      end
      frame(s, d, p, 1'b0, 4'h0, 1'b0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/parity_frame_tx.md
# parity_frame_tx

Serial frame transmitter that sits directly downstream of the parity generator. It accepts a data word and its precomputed parity bit over a valid/ready handshake, then serialises them LSB-first as a start bit, the data bits, the parity bit and a stop bit. Each bit is held for a programmable number of clock cycles. Its serial output feeds the link whose far end deserialises into the parity checker.

## Interface
- `DATA_W`, default 4: data bits per frame; legal range ≥1.
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range ≥1.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  a word and its parity bit are offered.
- `in_ready`  out  1  block can accept this cycle.
- `in_data`  in  DATA_W  word to send.
- `in_parity`  in  1  parity bit from the generator; sent unmodified.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle pulse in the final cycle of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- **Accept.** A handshake occurs when `in_valid && in_ready` at a rising edge. On a handshake the block:
  - latches `in_data` and `in_parity` into a shift register;
  - enters START;
  - clears the bit-cycle counter and the bit index.
- **Bit hold.** Every bit is held for exactly `CLKS_PER_BIT` cycles. The bit-cycle counter runs 0..`CLKS_PER_BIT`-1, and a tick is the cycle in which it equals `CLKS_PER_BIT`-1.
- **Transitions on tick:**
  - START → DATA.
  - DATA advances the bit index; after index `DATA_W`-1, DATA → PARITY.
  - PARITY → STOP.
  - STOP → IDLE, or → START if a handshake occurs in that same cycle.
- **Line levels:**
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx`=current LSB of the shift register; it shifts right on each DATA tick.
  - PARITY: `tx`=latched parity.
  - STOP: `tx`=1.
- **Status outputs:**
  - `in_ready` = (state==IDLE) or (STOP and tick). It is forced 0 while `rst` is high.
  - `busy` = 1 in every state except IDLE.
- Input changes after a handshake have no effect on the frame in flight.
- `in_valid` while not ready is ignored; no data is lost by the block. Holding the word until ready is the sender's job.
- **Reset.** Asserting `rst` at any point, including mid-frame, immediately forces:
  - state to IDLE;
  - `tx`=1, `busy`=0, `frame_done`=0;
  - counter, index and shift register to 0.
  
  The partial frame is abandoned and is not resumed.

## Timing
- `tx`, `busy` and `frame_done` are registered; reset values are 1, 0 and 0.
- `in_ready` is combinational from state and counter; its value during reset is 0.
- Latency: the start bit appears on `tx` in the cycle after the handshake edge.
- Frame length is (DATA_W+3)·CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle inclusive.
- `frame_done` is high for exactly 1 cycle per completed frame, in that last stop cycle.
- Back-to-back: a handshake in the last stop cycle starts the next start bit on the following cycle. There are zero idle cycles between frames.
- `CLKS_PER_BIT`=1: every cycle is a tick and each bit lasts one cycle. No off-by-one is permitted.
- Counter width is $clog2(CLKS_PER_BIT), minimum 1. The index width is $clog2(DATA_W), minimum 1. Neither counter wraps past its terminal value.

## Structure
- Package `parity_frame_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants START_BIT=1'b0 and STOP_BIT=1'b1;
  - the helper for a minimum-1 clog2 width.
- One sub-module, `parity_baud_tick`: the per-bit cycle counter with a clear input and a tick output, parameterised by `CLKS_PER_BIT`.
- Everything else (FSM, shift register, index, output registers) lives in `parity_frame_tx`.

## Test plan
- **Basic frame.** `DATA_W`=4, `CLKS_PER_BIT`=4, one handshake with `in_data`=4'b1011, `in_parity`=1.
  - Required `tx` bits: 0,1,1,0,1,1,1, each held 4 cycles (28 cycles total).
  - `frame_done` pulses once in cycle 28.
  - `busy` is high for all 28 cycles.
- **Back-to-back.** `in_valid` held high with 4'b0001/p=1, then 4'b1110/p=1.
  - Second start bit immediately follows the first stop bit with no idle gap.
  - Total 56 cycles and two `frame_done` pulses.
- **Mid-frame reset.** Assert `rst` in the 2nd data bit.
  - `tx`=1, `busy`=0 asynchronously.
  - After release, a new frame 4'b0101/p=0 transmits cleanly as 0,1,0,1,0,0,1.
- **Accept gating.** Toggle `in_valid` and `in_data` during a frame.
  - No handshake occurs and `tx` is unaffected.
  - `in_ready` rises only in the last stop cycle.
- **Minimum divider.** `CLKS_PER_BIT`=1, 4'b1111/p=0.
  - `tx`=0,1,1,1,1,0,1 on consecutive cycles.
  - `frame_done` pulses on cycle 7.
